// File: rtl/tff_pkg.sv
// Shared constants and helpers for the toggle-cell up/down counter family.
package tff_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam int   MODE_WRAP = 0;
  localparam int   MODE_SAT  = 1;

  // All-ones pattern of width w, right-aligned in 64 bits; callers truncate.
  function automatic logic [63:0] all_ones(input int unsigned w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop with synchronous parallel load; load wins over toggle.
module tff_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic res,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge res) begin
    if (res)
      q <= RST_BIT;
    else if (ld)
      q <= d;
    else if (t)
      q <= ~q;
  end

endmodule

// File: rtl/tff_updown_counter.sv
// WIDTH-bit up/down counter built from chained toggle cells, with load, wrap/saturate
// and a registered terminal-count pulse. Optional match output: TFF_UPDOWN_COUNTER_MATCH_EN.
module tff_updown_counter
  import tff_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0,
  parameter int          SATURATE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
`ifdef TFF_UPDOWN_COUNTER_MATCH_EN
  ,
  input  logic [WIDTH-1:0] match_val,
  output logic             match
`endif
);

  localparam logic [WIDTH-1:0] ONES  = WIDTH'(all_ones(WIDTH));
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
  localparam logic             SAT_ON = (SATURATE == MODE_SAT);

  logic             at_limit;
  logic             step;
  logic             hold;
  logic             run;
  logic [WIDTH-1:0] t;

  // Toggle-enable chain: each cell toggles only when every lower bit is at
  // the carry (up) or borrow (down) value. Saturation kills the whole chain.
  always_comb begin
    at_limit = (up_dn == DIR_DN) ? (q == '0) : (q == ONES);
    step     = en & ~load;
    hold     = SAT_ON & at_limit;
    run      = step & ~hold;
    t        = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      t[i] = run;
      run  = run & ((up_dn == DIR_UP) ? q[i] : ~q[i]);
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    tff_cell #(
      .RST_BIT (RST_Q[i])
    ) u_cell (
      .clk (clk),
      .res (res),
      .t   (t[i]),
      .ld  (load),
      .d   (load_val[i]),
      .q   (q[i])
    );
  end

  // Boundary events only come from count steps, never from a load.
  always_ff @(posedge clk or posedge res) begin
    if (res)
      tc <= 1'b0;
    else
      tc <= step & at_limit;
  end

`ifdef TFF_UPDOWN_COUNTER_MATCH_EN
  logic [WIDTH-1:0] q_nxt;

  assign q_nxt = load ? load_val : (q ^ t);

  always_ff @(posedge clk or posedge res) begin
    if (res)
      match <= 1'b0;
    else
      match <= (load | en) & (q_nxt == match_val);
  end
`endif

endmodule

// File: tb/tb_tff_updown_counter.sv
// Bench for tff_updown_counter: vector table, hand sequences and a random run
// checked against an arithmetic model, on a wrapping and a saturating instance.
module tb_tff_updown_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         res;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] qw, qs;
  logic         tcw, tcs;
`ifdef TFF_UPDOWN_COUNTER_MATCH_EN
  logic [W-1:0] match_val;
  logic         mw, ms;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mqw, mqs;
  logic         mtw, mts;
  logic         mmw, mms;

  always #5 clk = ~clk;

  tff_updown_counter #(.WIDTH(W), .RESET_VAL(5), .SATURATE(0)) u_wrap (
    .clk (clk), .res (res), .en (en), .up_dn (up_dn), .load (load),
    .load_val (load_val), .q (qw), .tc (tcw)
`ifdef TFF_UPDOWN_COUNTER_MATCH_EN
    , .match_val (match_val), .match (mw)
`endif
  );

  tff_updown_counter #(.WIDTH(W), .RESET_VAL(5), .SATURATE(1)) u_sat (
    .clk (clk), .res (res), .en (en), .up_dn (up_dn), .load (load),
    .load_val (load_val), .q (qs), .tc (tcs)
`ifdef TFF_UPDOWN_COUNTER_MATCH_EN
    , .match_val (match_val), .match (ms)
`endif
  );

  typedef struct {
    bit       ld;
    bit [3:0] lv;
    bit       e;
    bit       u;
    bit [3:0] qw;
    bit       tw;
    bit [3:0] qs;
    bit       ts;
  } vec_t;

  vec_t vec [20];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference step in plain arithmetic: returns {tc, q}.
  function automatic logic [W:0] mstep(input logic [W-1:0] q, input logic ld,
                                       input logic [W-1:0] lv, input logic e,
                                       input logic u, input bit sat);
    int top;
    int v;
    top = (1 << W) - 1;
    v   = int'(q);
    if (ld) return {1'b0, lv};
    if (!e) return {1'b0, q};
    if (u) begin
      if (v == top) return {1'b1, sat ? q : W'(0)};
      return {1'b0, W'(v + 1)};
    end
    if (v == 0) return {1'b1, sat ? q : W'(top)};
    return {1'b0, W'(v - 1)};
  endfunction

  task automatic cycle(input logic ld, input logic [W-1:0] lv, input logic e, input logic u);
    logic [W:0] rw, rs;
    load = ld; load_val = lv; en = e; up_dn = u;
    rw = mstep(mqw, ld, lv, e, u, 1'b0);
    rs = mstep(mqs, ld, lv, e, u, 1'b1);
`ifdef TFF_UPDOWN_COUNTER_MATCH_EN
    mmw = (ld | e) && (rw[W-1:0] == match_val);
    mms = (ld | e) && (rs[W-1:0] == match_val);
`endif
    tick();
    {mtw, mqw} = rw;
    {mts, mqs} = rs;
    check("rand_q_wrap", int'(qw), int'(mqw));
    check("rand_tc_wrap", int'(tcw), int'(mtw));
    check("rand_q_sat", int'(qs), int'(mqs));
    check("rand_tc_sat", int'(tcs), int'(mts));
`ifdef TFF_UPDOWN_COUNTER_MATCH_EN
    check("rand_match_wrap", int'(mw), int'(mmw));
    check("rand_match_sat", int'(ms), int'(mms));
`endif
  endtask

  task automatic async_reset();
    #2 res = 1'b1;
    #1;
    check("areset_q_wrap", int'(qw), 5);
    check("areset_tc_wrap", int'(tcw), 0);
    check("areset_q_sat", int'(qs), 5);
    check("areset_tc_sat", int'(tcs), 0);
`ifdef TFF_UPDOWN_COUNTER_MATCH_EN
    check("areset_match", int'(mw | ms), 0);
`endif
    #1 res = 1'b0;
    mqw = 4'd5; mqs = 4'd5; mtw = 1'b0; mts = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    res = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
`ifdef TFF_UPDOWN_COUNTER_MATCH_EN
    match_val = 4'd3;
`endif
    #12;
    check("reset_q_wrap", int'(qw), 5);
    check("reset_tc_wrap", int'(tcw), 0);
    check("reset_q_sat", int'(qs), 5);
    tick();
    res = 1'b0;

    // Mid-cycle reset from q=9, then first count after release.
    load = 1'b1; load_val = 4'd9;
    tick();
    check("load9_q", int'(qw), 9);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    #2 res = 1'b1;
    #1;
    check("midreset_q", int'(qw), 5);
    check("midreset_tc", int'(tcw), 0);
    #1 res = 1'b0;
    tick();
    check("post_reset_q_wrap", int'(qw), 6);
    check("post_reset_q_sat", int'(qs), 6);
    en = 1'b0;

    vec = '{
      '{1, 14, 0, 1, 14, 0, 14, 0},
      '{0,  0, 1, 1, 15, 0, 15, 0},
      '{0,  0, 1, 1,  0, 1, 15, 1},
      '{0,  0, 1, 1,  1, 0, 15, 1},
      '{1,  1, 0, 0,  1, 0,  1, 0},
      '{0,  0, 1, 0,  0, 0,  0, 0},
      '{0,  0, 1, 0, 15, 1,  0, 1},
      '{0,  0, 1, 0, 14, 0,  0, 1},
      '{1,  3, 0, 1,  3, 0,  3, 0},
      '{1,  7, 1, 1,  7, 0,  7, 0},
      '{1,  8, 0, 1,  8, 0,  8, 0},
      '{0,  0, 1, 1,  9, 0,  9, 0},
      '{0,  0, 1, 0,  8, 0,  8, 0},
      '{0,  0, 1, 0,  7, 0,  7, 0},
      '{0,  0, 0, 0,  7, 0,  7, 0},
      '{0,  0, 0, 1,  7, 0,  7, 0},
      '{1, 15, 1, 1, 15, 0, 15, 0},
      '{0,  0, 0, 1, 15, 0, 15, 0},
      '{1,  0, 1, 0,  0, 0,  0, 0},
      '{0,  0, 1, 1,  1, 0,  1, 0}
    };

    foreach (vec[i]) begin
      load = vec[i].ld; load_val = vec[i].lv; en = vec[i].e; up_dn = vec[i].u;
      tick();
      check($sformatf("vec%0d_q_wrap", i), int'(qw), int'(vec[i].qw));
      check($sformatf("vec%0d_tc_wrap", i), int'(tcw), int'(vec[i].tw));
      check($sformatf("vec%0d_q_sat", i), int'(qs), int'(vec[i].qs));
      check($sformatf("vec%0d_tc_sat", i), int'(tcs), int'(vec[i].ts));
    end
    mqw = qw_exp_last(); mqs = mqw; mtw = 1'b0; mts = 1'b0;

`ifdef TFF_UPDOWN_COUNTER_MATCH_EN
    // match fires exactly in the cycle q=3.
    match_val = 4'd3;
    cycle(1'b1, 4'd1, 1'b0, 1'b1);
    check("match_q1", int'(mw), 0);
    cycle(1'b0, 4'd0, 1'b1, 1'b1);
    check("match_q2", int'(mw), 0);
    cycle(1'b0, 4'd0, 1'b1, 1'b1);
    check("match_q3", int'(mw), 1);
    cycle(1'b0, 4'd0, 1'b1, 1'b1);
    check("match_q4", int'(mw), 0);
`endif

    for (int n = 0; n < 600; n++) begin
      logic [W-1:0] lv;
      case ($urandom_range(0, 3))
        0:       lv = 4'd0;
        1:       lv = 4'd15;
        default: lv = W'($urandom);
      endcase
`ifdef TFF_UPDOWN_COUNTER_MATCH_EN
      if ($urandom_range(0, 15) == 0) match_val = W'($urandom);
`endif
      cycle(($urandom_range(0, 9) == 0), lv, ($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 1)));
      if ($urandom_range(0, 49) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [W-1:0] qw_exp_last();
    return W'(vec[19].qw);
  endfunction

endmodule

// File: doc/tff_updown_counter.md
Name: tff_updown_counter

Overview:
- Parametrised synchronous up/down counter built from a bank of WIDTH toggle cells. It is the next generation of the single toggle flip-flop.
- Adds the following over a single toggle cell:
  - per-bit toggle-enable chaining
  - direction control
  - parallel load
  - wrap or saturate at the boundaries
  - a registered terminal-count pulse
- Used as a general event/interval counter in timer, divider and sequencer blocks.

Parameters:
- WIDTH, 8: counter width in bits (>=2).
- RESET_VAL, 0: value of q after reset (WIDTH bits, truncated).
- SATURATE, 0: 0 = wrap at the boundaries; 1 = hold at all-ones (up) or zero (down).

Ports:
- clk  input  1  rising-edge clock.
- res  input  1  reset; asynchronous, active-high.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value written on load.
- q  output  WIDTH  registered counter value.
- tc  output  1  registered terminal-count pulse, one cycle wide.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - res is asynchronous, active-high. While res=1: q=RESET_VAL, tc=0, regardless of clk.
  - Release of res is seen at the next rising clk edge. The first count can occur on that edge if en=1.
- Per-edge priority:
  - load=1: q<=load_val; tc<=0; en and up_dn ignored.
  - else en=1: count step, described below.
  - else: q holds; tc<=0.
- Count step, realised as a toggle-cell bank:
  - Bit 0 toggle enable t[0]=en.
  - Up direction: t[i]=t[i-1] & q[i-1].
  - Down direction: t[i]=t[i-1] & ~q[i-1].
  - Each cell toggles when its t is 1. Net result: q±1 mod 2^WIDTH in one cycle.
- Boundary, up direction (up_dn=1, q=all-ones, en=1):
  - SATURATE=0: q wraps to 0; tc<=1 on the same edge, visible for the following cycle.
  - SATURATE=1: q holds at all-ones; tc<=1 on every enabled cycle spent at the limit.
- Boundary, down direction (up_dn=0, q=0, en=1):
  - SATURATE=0: q wraps to all-ones; tc<=1.
  - SATURATE=1: q holds at 0; tc<=1 on every enabled cycle spent at the limit.
- tc timing: tc is 0 on all other edges. It is a one-cycle pulse per boundary event, with latency 1 cycle from the boundary edge.
- Direction change:
  - up_dn may change on any cycle.
  - It takes effect on the same edge; no pipeline state to flush.
- load with load_val equal to a boundary value: no tc is generated. tc only fires on a count step.
- Reset mid-count: q and tc are forced immediately (asynchronously). No partial state survives.

Optional Feature:
- Macro: TFF_UPDOWN_COUNTER_MATCH_EN.
- When defined:
  - Adds input match_val (WIDTH) and output match (1).
  - match is registered: match<=1 on any edge where the next q equals match_val, via load or count.
  - match resets to 0.
  - When en=0 and load=0, match<=0.
- When undefined:
  - The ports do not exist.
  - No comparator logic is generated.

Decomposition:
- Shared package tff_pkg:
  - localparam-style constants DIR_UP=1'b1, DIR_DN=1'b0.
  - MODE_WRAP=0, MODE_SAT=1.
  - Helper function computing the all-ones value for a given width.
- One sub-module: tff_cell.
  - Ports: clk, res (async active-high), t, ld, d, q.
  - Behaviour: ld has priority over t; toggles on t=1.
  - Instantiated WIDTH times via generate.
  - Saturation gating (force t=0 at the limit) and tc generation live in the top level.

Test Plan:
- Reset:
  - Stimulus: assert res mid-cycle with WIDTH=4, RESET_VAL=5, q=9.
  - Response: q=5 and tc=0 immediately, without a clock edge. After release with en=1, up_dn=1: q=6 on the first edge.
- Wrap up:
  - Stimulus: WIDTH=4, SATURATE=0, load 14, then en=1, up_dn=1 for 3 cycles.
  - Response: q=15, 0, 1. tc=1 only in the cycle where q=0.
- Saturate down:
  - Stimulus: WIDTH=4, SATURATE=1, load 1, then en=1, up_dn=0 for 3 cycles.
  - Response: q=0, 0, 0. tc=0, 1, 1 in the corresponding cycles after the edges at q=0.
- Load priority:
  - Stimulus: load=1, load_val=7, en=1, up_dn=1 with q=3.
  - Response: q=7, not 4; tc=0.
- Direction flip and hold:
  - Stimulus: q=8, en=1; up_dn sequence 1, 0, 0; then en=0 for 2 cycles.
  - Response: q=9, 8, 7, 7, 7.
- Match (macro defined):
  - Stimulus: match_val=3, load 1, count up.
  - Response: match=1 exactly in the cycle q=3; 0 otherwise.
